ama_riscv_ret_trace_buf: RTL
============================

// Module: ama_riscv_ret_trace_buf
// PURPOSE
// - Retirement trace buffer; sits directly downstream of the core view's per-instruction retirement record.
// - Captures one record per retired instruction into a FIFO and drains it to a trace sink over a valid/ready port.
// - Counts dropped records when the FIFO is full.
// - Optionally keeps retirement/branch performance counters.
// PARAMETERS
// - DEPTH     8   FIFO entries; power of 2, >= 2
// - CNT_W     32  width of the drop counter and perf counters
// PORTS
// - clk            in   1      core clock
// - rst            in   1      synchronous, active-high reset
// - ret_valid      in   1      a record is presented this cycle (inst_retired)
// - ret_inst       in   32     retired instruction
// - ret_pc         in   32     retired PC
// - ret_br_inst    in   1      retired inst is a branch
// - ret_br_taken   in   1      branch was taken
// - ret_bp_hit     in   1      branch predictor hit
// - ret_dmem_addr  in   32     data memory address (0 if no access)
// - ret_dmem_size  in   4      0-7 = lb,lh,lw,ld,sb,sh,sw,sd; 8 = no access
// - out_valid      out  1      head record valid
// - out_ready      in   1      sink accepts the head record
// - out_inst       out  32     head record: instruction
// - out_pc         out  32     head record: PC
// - out_flags      out  3      head record: {bp_hit, br_taken, br_inst}
// - out_dmem_addr  out  32     head record: data memory address
// - out_dmem_size  out  4      head record: access size code
// - level          out  $clog2(DEPTH)+1  current occupancy
// - drop_cnt       out  CNT_W  records lost to a full FIFO; saturating
// - overflow       out  1      sticky; set on the first drop
// BEHAVIOUR
// - Reset (sync, active-high):
//   - rd/wr pointers 0, level 0, out_valid 0, all out_* 0.
//   - drop_cnt 0, overflow 0, perf counters 0.
//   - Reset mid-drain discards the FIFO contents.
// - Push: ret_valid && (!full || pop). The record is written at the write pointer; the pointer increments mod DEPTH.
// - Pop: out_valid && out_ready. The read pointer increments mod DEPTH.
// - Full and empty are evaluated on registered state at the start of the cycle.
// - Simultaneous push and pop when full: both happen; level stays DEPTH; no drop.
// - Simultaneous push and pop when empty: push only (no bypass); out_valid rises next cycle.
// - Latency: a record pushed in cycle N appears on out_* in cycle N+1.
// - out_* is read combinationally from the head entry and is 0 when empty.
// - out_* is stable while out_valid && !out_ready.
// - Drop: ret_valid && full && !pop.
//   - drop_cnt increments, saturating at all-ones.
//   - overflow is set and held until rst.
// - level = wr_ptr - rd_ptr with an extra wrap bit. full = (level == DEPTH); empty = (level == 0).
// - Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
// - Records with ret_valid = 0 are ignored regardless of the other inputs.
// CONFIGURATION
// - RET_TRACE_PERF_EN defined:
//   - Adds outputs cnt_ret, cnt_br, cnt_br_taken, cnt_bp_hit, each CNT_W wide and saturating.
//   - Counters increment on every ret_valid cycle, including dropped records.
//   - cnt_br increments when ret_br_inst; cnt_br_taken when ret_br_inst && ret_br_taken; cnt_bp_hit when ret_br_inst && ret_bp_hit.
// - RET_TRACE_PERF_EN undefined: those ports and registers do not exist; all other behaviour is identical.
// TESTING
// - Reset, then 3 pushes (pc 0x100/0x104/0x108) with out_ready=1
//   -> out_pc 0x100/0x104/0x108 on cycles 1/2/3; level ends at 0.
// - out_ready=0, 10 pushes with DEPTH=8 -> level=8, drop_cnt=2, overflow=1.
//   Drain -> first 8 PCs out in order.
// - Full FIFO, push and pop in the same cycle -> level stays 8, drop_cnt unchanged, new record at the tail.
// - Stall with out_ready=0 for 5 cycles -> out_* unchanged; the head pops on the first out_ready=1 cycle.
// - rst asserted with level=5 -> next cycle: out_valid=0, level=0, drop_cnt=0, overflow=0.
// - PERF_EN: 4 branches, 3 taken, 2 bp_hit, 2 non-branches, one dropped
//   -> cnt_ret=6, cnt_br=4, cnt_br_taken=3, cnt_bp_hit=2.

Source files
------------

// File: rtl/ama_riscv_ret_trace_buf_if.sv
// Retirement-record and trace-sink signal bundle for ama_riscv_ret_trace_buf.
// master drives retirement records and sink ready; slave is the trace buffer.
interface ama_riscv_ret_trace_buf_if;
  logic        ret_valid;
  logic [31:0] ret_inst;
  logic [31:0] ret_pc;
  logic        ret_br_inst;
  logic        ret_br_taken;
  logic        ret_bp_hit;
  logic [31:0] ret_dmem_addr;
  logic [3:0]  ret_dmem_size;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_flags;
  logic [31:0] out_dmem_addr;
  logic [3:0]  out_dmem_size;

  modport master (
    output ret_valid, ret_inst, ret_pc, ret_br_inst, ret_br_taken, ret_bp_hit,
           ret_dmem_addr, ret_dmem_size, out_ready,
    input  out_valid, out_inst, out_pc, out_flags, out_dmem_addr, out_dmem_size
  );

  modport slave (
    input  ret_valid, ret_inst, ret_pc, ret_br_inst, ret_br_taken, ret_bp_hit,
           ret_dmem_addr, ret_dmem_size, out_ready,
    output out_valid, out_inst, out_pc, out_flags, out_dmem_addr, out_dmem_size
  );
endinterface

// File: rtl/ama_riscv_ret_trace_buf.sv
// Retirement trace FIFO with saturating drop counter and sticky overflow flag.
// Define RET_TRACE_PERF_EN to add saturating retirement/branch performance counters.
module ama_riscv_ret_trace_buf #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  ama_riscv_ret_trace_buf_if.slave bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
`ifdef RET_TRACE_PERF_EN
  ,
  output logic [CNT_W-1:0]         cnt_ret,
  output logic [CNT_W-1:0]         cnt_br,
  output logic [CNT_W-1:0]         cnt_br_taken,
  output logic [CNT_W-1:0]         cnt_bp_hit
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  flags;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_size;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  rec_t             mem [DEPTH];
  rec_t             rec_in, head;
  logic             full, empty, push, pop, drop;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  // Pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop  = !empty && bus.out_ready;
  assign push = bus.ret_valid && (!full || pop);
  assign drop = bus.ret_valid && full && !pop;

  assign rec_in.inst      = bus.ret_inst;
  assign rec_in.pc        = bus.ret_pc;
  assign rec_in.flags     = {bus.ret_bp_hit, bus.ret_br_taken, bus.ret_br_inst};
  assign rec_in.dmem_addr = bus.ret_dmem_addr;
  assign rec_in.dmem_size = bus.ret_dmem_size;

  // Head is gated to zero when empty, so storage needs no reset.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign bus.out_valid     = !empty;
  assign bus.out_inst      = head.inst;
  assign bus.out_pc        = head.pc;
  assign bus.out_flags     = head.flags;
  assign bus.out_dmem_addr = head.dmem_addr;
  assign bus.out_dmem_size = head.dmem_size;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

`ifdef RET_TRACE_PERF_EN
  // Counters see every retirement, including records the FIFO drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ret      <= '0;
      cnt_br       <= '0;
      cnt_br_taken <= '0;
      cnt_bp_hit   <= '0;
    end else if (bus.ret_valid) begin
      cnt_ret <= sat_inc(cnt_ret);
      if (bus.ret_br_inst) cnt_br <= sat_inc(cnt_br);
      if (bus.ret_br_inst && bus.ret_br_taken) cnt_br_taken <= sat_inc(cnt_br_taken);
      if (bus.ret_br_inst && bus.ret_bp_hit) cnt_bp_hit <= sat_inc(cnt_bp_hit);
    end
  end
`endif

endmodule
